// File: rtl/seg_adder_pipe.sv
// ---------------------------------------------------------------------------
// seg_adder_pipe
//
// Pipelined multi-precision adder/subtractor. Each beat carries two
// N_LANES x LANE_W operands. A per-beat segment mask splits the operands into
// independent segments. Each segment is added (or subtracted) as one wide
// integer. The carry ripples one lane per pipeline stage.
//
// Pipeline organisation (N_LANES+1 register ranks):
//   rank 0     : captured inputs (a, bb = sub ? ~b : b, seg, sub).
//   rank k+1   : stage k has replaced lane k of the data word with its sum.
//                Lanes > k still hold the original A lanes. Lanes < k hold
//                finished sums.
//   rank N     : output register (sum_o, valid_o, cout_o).
// The latency from the accept edge to valid_o is therefore N_LANES cycles.
//
// Handshake: adv = !valid_o || ready_i. When adv is high every rank shifts
// and rank 0 captures the input, so a beat is accepted on valid_i && ready_o.
// When adv is low every rank, including its valid bit, holds.
//
// Optional feature macro: SEG_ADDER_COUT_EN
//   When this macro is defined, the cout_o port exists and carries the
//   per-lane carry-out, registered together with sum_o.
//   When it is undefined, the port and its carry-capture registers are absent.
//
// Ports:
//   clk_i    : clock; all state changes on the rising edge
//   rst_i    : synchronous, active-high reset
//   valid_i  : input beat valid
//   ready_o  : block accepts a beat this cycle
//   a_i, b_i : operands; lane j = bits [j*LANE_W +: LANE_W]
//   seg_i    : segment mask (lanes-per-segment - 1)
//   sub_i    : 1 = A - B, 0 = A + B (per segment)
//   valid_o  : result valid
//   ready_i  : downstream accepts the result
//   sum_o    : segmented result, same lane mapping as the operands
//   cout_o   : per-lane carry-out (only with SEG_ADDER_COUT_EN)
// ---------------------------------------------------------------------------
module seg_adder_pipe #(
  parameter int N_LANES = 8,
  parameter int LANE_W  = 32,
  parameter int SEG_W   = $clog2(N_LANES)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [N_LANES*LANE_W-1:0]   a_i,
  input  logic [N_LANES*LANE_W-1:0]   b_i,
  input  logic [SEG_W-1:0]            seg_i,
  input  logic                        sub_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [N_LANES*LANE_W-1:0]   sum_o
`ifdef SEG_ADDER_COUT_EN
  ,
  output logic [N_LANES-1:0]          cout_o
`endif
);

  localparam int TW = N_LANES * LANE_W;

  // Per-rank valid bits: bit r belongs to rank r.
  logic [N_LANES:0] v_q;
  logic             adv;

  // Data word per rank. It holds the A lanes not yet summed and the sums
  // already produced.
  logic [TW-1:0]    x_q   [0:N_LANES];
  logic [TW-1:0]    x_d   [0:N_LANES];
  // B lanes after the optional inversion. They are only needed until the
  // last stage consumes them.
  logic [TW-1:0]    bb_q  [0:N_LANES-1];
  logic [TW-1:0]    bb_d  [0:N_LANES-1];
  logic [SEG_W-1:0] seg_q [0:N_LANES-1];
  logic [SEG_W-1:0] seg_d [0:N_LANES-1];
  logic             sub_q [0:N_LANES-1];
  logic             sub_d [0:N_LANES-1];
  // Carry out of lane k-1, entering stage k. Stage 0 always starts a
  // segment, so no rank 0 carry exists.
  logic             carry_q [1:N_LANES-1];
  logic             carry_d [1:N_LANES-1];
`ifdef SEG_ADDER_COUT_EN
  // Carry bits collected so far: bit j is valid from rank j+1 onward.
  logic [N_LANES-1:0] cout_q [1:N_LANES];
  logic [N_LANES-1:0] cout_d [1:N_LANES];
`endif

  // Handshake: the whole pipe advances unless a result is being held back.
  assign adv     = !v_q[N_LANES] || ready_i;
  assign ready_o = adv;

  // Rank 0 next state: capture the inputs.
  assign x_d[0]   = a_i;
  assign bb_d[0]  = sub_i ? ~b_i : b_i;
  assign seg_d[0] = seg_i;
  assign sub_d[0] = sub_i;

  for (genvar k = 0; k < N_LANES; k++) begin : g_stage
    logic              cin;
    logic [LANE_W:0]   res;
    logic [TW-1:0]     xn;

    // Lane k starts a segment when (k & seg) == 0. The carry-in at a segment
    // start is sub, which completes the two's complement of B.
    if (k == 0) begin : g_cin_first
      assign cin = sub_q[0];
    end else begin : g_cin_rest
      assign cin = ((SEG_W'(k) & seg_q[k]) == '0) ? sub_q[k] : carry_q[k];
    end

    assign res = {1'b0, x_q[k][k*LANE_W +: LANE_W]}
               + {1'b0, bb_q[k][k*LANE_W +: LANE_W]}
               + {{LANE_W{1'b0}}, cin};

    always_comb begin
      xn = x_q[k];
      xn[k*LANE_W +: LANE_W] = res[LANE_W-1:0];
    end
    assign x_d[k+1] = xn;

    if (k < N_LANES - 1) begin : g_fwd
      assign bb_d[k+1]    = bb_q[k];
      assign seg_d[k+1]   = seg_q[k];
      assign sub_d[k+1]   = sub_q[k];
      assign carry_d[k+1] = res[LANE_W];
    end

`ifdef SEG_ADDER_COUT_EN
    if (k == 0) begin : g_cout_first
      assign cout_d[1] = {{(N_LANES-1){1'b0}}, res[LANE_W]};
    end else begin : g_cout_rest
      assign cout_d[k+1] = cout_q[k] | (N_LANES'(res[LANE_W]) << k);
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q <= '0;
      for (int r = 0; r <= N_LANES; r++) x_q[r] <= '0;
      for (int r = 0; r < N_LANES; r++) begin
        bb_q[r]  <= '0;
        seg_q[r] <= '0;
        sub_q[r] <= 1'b0;
      end
      for (int r = 1; r < N_LANES; r++) carry_q[r] <= 1'b0;
`ifdef SEG_ADDER_COUT_EN
      for (int r = 1; r <= N_LANES; r++) cout_q[r] <= '0;
`endif
    end else if (adv) begin
      // A beat is accepted exactly when valid_i is high here, because
      // ready_o == adv.
      v_q <= {v_q[N_LANES-1:0], valid_i};
      for (int r = 0; r <= N_LANES; r++) x_q[r] <= x_d[r];
      for (int r = 0; r < N_LANES; r++) begin
        bb_q[r]  <= bb_d[r];
        seg_q[r] <= seg_d[r];
        sub_q[r] <= sub_d[r];
      end
      for (int r = 1; r < N_LANES; r++) carry_q[r] <= carry_d[r];
`ifdef SEG_ADDER_COUT_EN
      for (int r = 1; r <= N_LANES; r++) cout_q[r] <= cout_d[r];
`endif
    end
  end

  assign valid_o = v_q[N_LANES];
  assign sum_o   = x_q[N_LANES];
`ifdef SEG_ADDER_COUT_EN
  assign cout_o  = cout_q[N_LANES];
`endif

endmodule

// File: tb/tb_seg_adder_pipe.sv
// ---------------------------------------------------------------------------
// tb_seg_adder_pipe
//
// Self-checking bench for seg_adder_pipe (default parameters). The driver
// pushes the reference result of every accepted beat into exp_q. A monitor
// pops and compares each beat that leaves the DUT. The reference model treats
// each segment as one wide integer.
// Handshake on both sides: a transfer happens on a rising edge where valid
// and ready are both high. The bench changes inputs 1 time unit after the
// rising edge and samples on the falling edge.
// ---------------------------------------------------------------------------
module tb_seg_adder_pipe;
  localparam int N  = 8;
  localparam int W  = 32;
  localparam int SW = $clog2(N);
  localparam int TW = N * W;
`ifdef SEG_ADDER_COUT_EN
  localparam int EW = TW + N;
`else
  localparam int EW = TW;
`endif

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [TW-1:0] a_i = '0;
  logic [TW-1:0] b_i = '0;
  logic [SW-1:0] seg_i = '0;
  logic          sub_i = 1'b0;
  logic          valid_o;
  logic          ready_i = 1'b1;
  logic [TW-1:0] sum_o;
  logic [EW-1:0] dut_out;
`ifdef SEG_ADDER_COUT_EN
  logic [N-1:0]  cout_o;
  assign dut_out = {cout_o, sum_o};
`else
  assign dut_out = sum_o;
`endif

  seg_adder_pipe #(.N_LANES(N), .LANE_W(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .a_i     (a_i),
    .b_i     (b_i),
    .seg_i   (seg_i),
    .sub_i   (sub_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .sum_o   (sum_o)
`ifdef SEG_ADDER_COUT_EN
    ,
    .cout_o  (cout_o)
`endif
  );

  // ---------------- clock / reset -----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit rnd_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- scoreboard state -----------------
  logic [EW-1:0] exp_q[$];
  int            lat_q[$];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model. Segments are runs of lanes that begin where
  // (j & seg) == 0. Each run is one wide integer: A + (sub ? ~B : B) + sub,
  // taken modulo the run width. The carry of lane j is the bit just above
  // the partial sum of the run's lanes up to and including j.
  function automatic logic [EW-1:0] model(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                          input logic [SW-1:0] seg, input bit sub);
    logic [TW-1:0] sum;
    logic [N-1:0]  co;
    logic [TW:0]   aa, bv, m, p;
    int            start, w;
    start = 0;
    sum = '0;
    co = '0;
    for (int j = 0; j < N; j++) begin
      if ((SW'(j) & seg) == '0) start = j;
      aa = {1'b0, a} >> (start * W);
      bv = {1'b0, (sub ? ~b : b)} >> (start * W);
      w  = (j - start + 1) * W;
      m  = ({{TW{1'b0}}, 1'b1} << w) - 1;
      p  = (aa & m) + (bv & m) + {{TW{1'b0}}, sub};
      co[j] = p[w];
      sum[j*W +: W] = p[(j - start) * W +: W];
    end
`ifdef SEG_ADDER_COUT_EN
    return {co, sum};
`else
    return sum;
`endif
  endfunction

  // Random operand with a bias toward carry-heavy lane values.
  function automatic logic [TW-1:0] rand_op();
    logic [TW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) begin
      case ($urandom_range(0, 5))
        0:       v[j*W +: W] = 32'h0000_0000;
        1:       v[j*W +: W] = 32'hFFFF_FFFF;
        2:       v[j*W +: W] = 32'h0000_0001;
        default: v[j*W +: W] = $urandom;
      endcase
    end
    return v;
  endfunction

  // ---------------- driver -----------------
  // Called 1 time unit after a rising edge. It returns at the same phase
  // once the beat has been accepted.
  task automatic send(input logic [TW-1:0] a, input logic [TW-1:0] b,
                      input logic [SW-1:0] seg, input bit sub, input bit chk_lat);
    int  waited;
    bit  done;
    waited = 0;
    done = 1'b0;
    valid_i = 1'b1;
    a_i = a;
    b_i = b;
    seg_i = seg;
    sub_i = sub;
    while (!done) begin
      @(negedge clk);
      if (ready_o) begin
        exp_q.push_back(model(a, b, seg, sub));
        lat_q.push_back(chk_lat ? cyc + 1 : -1);
        done = 1'b1;
      end else if (waited++ > 1000) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: ready_o stuck low for %0d cycles", waited);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
    end
    // Extra cycles so that any spurious output is seen by the monitor.
    repeat (20) @(posedge clk);
    #1;
  endtask

  // ---------------- monitor -----------------
  bit            prev_stall = 1'b0;
  logic [EW-1:0] prev_out;
  always @(negedge clk) begin
    if (rst_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_hold", EW'(valid_o), EW'(1));
        chk("stall_data_hold", dut_out, prev_out);
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h expected no beat", dut_out);
        end else begin
          logic [EW-1:0] e;
          int            l;
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          chk("result", dut_out, e);
          if (l >= 0) chk("latency", EW'(cyc - l), EW'(N));
        end
      end
      prev_stall = valid_o && !ready_i;
      prev_out   = dut_out;
    end
  end

  // ---------------- stimulus -----------------
  logic [TW-1:0] all_f, ones, lane0_one;
  logic [SW-1:0] seg_cycle [4];

  initial begin
    all_f     = {N{32'hFFFF_FFFF}};
    ones      = {N{32'h0000_0001}};
    lane0_one = {{(N-1){32'h0}}, 32'h0000_0001};
    seg_cycle[0] = SW'(0);
    seg_cycle[1] = SW'(1);
    seg_cycle[2] = SW'(3);
    seg_cycle[3] = SW'(7);

    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("reset_valid_o", EW'(valid_o), EW'(0));
    chk("reset_ready_o", EW'(ready_o), EW'(1));
    chk("reset_sum_o", dut_out, EW'(0));
    @(posedge clk);
    #1;

    // Directed beats, issued back to back, with a latency check.
    send(all_f, ones, SW'(0), 1'b0, 1'b1);
    send(all_f, ones, SW'(7), 1'b0, 1'b1);
    send('0, lane0_one, SW'(1), 1'b1, 1'b1);
    send(all_f, all_f, SW'(3), 1'b1, 1'b1);

    // Back-to-back beats cycling through the legal segment modes.
    for (int i = 0; i < 64; i++)
      send(rand_op(), rand_op(), seg_cycle[i % 4], 1'($urandom_range(0, 1)), 1'b1);
    drain();

    // Random downstream stalls, source gaps and all seg values, including
    // seg values that are not of the form 2^k-1.
    rnd_ready = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(rand_op(), rand_op(), SW'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
    rnd_ready = 1'b0;
    drain();

    // Reset with 5 beats in flight. The beats are discarded, and the next
    // beat has normal latency.
    for (int i = 0; i < 5; i++)
      send(rand_op(), rand_op(), SW'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)), 1'b1);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    chk("midreset_valid_o", EW'(valid_o), EW'(0));
    chk("midreset_ready_o", EW'(ready_o), EW'(1));
    @(posedge clk);
    #1;
    send(rand_op(), rand_op(), SW'(3), 1'b1, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog (about 80k cycles).
  initial begin
    #800000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
